// File: rtl/disp_scheduler.sv
// Display source scheduler for the 4-digit score display: live score background,
// timed overlay messages via req/ack, and an alert blink that blanks to dashes.
module disp_scheduler #(
    parameter int HOLD_TICKS  = 1000,
    parameter int BLINK_TICKS = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic [7:0]  score_a,
    input  logic [7:0]  score_b,
    input  logic        ovl_req,
    input  logic [15:0] ovl_data,
    input  logic        ovl_clr,
    input  logic        blink_en,
    output logic [15:0] disp_data,
    output logic        ovl_ack,
    output logic        ovl_busy,
    output logic [1:0]  src
);

    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam int BW = $clog2(BLINK_TICKS + 1);

    localparam logic [1:0] SRC_SCORE   = 2'd0;
    localparam logic [1:0] SRC_OVERLAY = 2'd1;
    localparam logic [1:0] SRC_BLANK   = 2'd2;

    typedef enum logic {
        SCORE,
        OVERLAY
    } state_t;

    state_t        state, state_nx;
    logic [15:0]   ovl_reg, ovl_reg_nx;
    logic [HW-1:0] hold_cnt, hold_cnt_nx;
    logic [BW-1:0] blk_cnt, blk_cnt_nx;
    logic          phase, phase_nx;
    logic          ack_nx;
    logic [15:0]   disp_nx;
    logic [1:0]    src_nx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SCORE;
            ovl_reg   <= 16'h0000;
            hold_cnt  <= '0;
            blk_cnt   <= BW'(BLINK_TICKS);
            phase     <= 1'b1;
            ovl_ack   <= 1'b0;
            disp_data <= 16'h0000;
            src       <= SRC_SCORE;
        end else begin
            state     <= state_nx;
            ovl_reg   <= ovl_reg_nx;
            hold_cnt  <= hold_cnt_nx;
            blk_cnt   <= blk_cnt_nx;
            phase     <= phase_nx;
            ovl_ack   <= ack_nx;
            disp_data <= disp_nx;
            src       <= src_nx;
        end
    end

    // Abort beats a new request, which beats the hold countdown; a request seen
    // while the previous ack is still high is the same request, so it is skipped.
    always_comb begin
        state_nx    = state;
        ovl_reg_nx  = ovl_reg;
        hold_cnt_nx = hold_cnt;
        ack_nx      = 1'b0;
        if (state == OVERLAY && ovl_clr) begin
            state_nx    = SCORE;
            hold_cnt_nx = '0;
        end else if (ovl_req && !ovl_ack) begin
            state_nx    = OVERLAY;
            ovl_reg_nx  = ovl_data;
            hold_cnt_nx = HW'(HOLD_TICKS);
            ack_nx      = 1'b1;
        end else if (state == OVERLAY && tick) begin
            hold_cnt_nx = hold_cnt - HW'(1);
            if (hold_cnt == HW'(1)) begin
                state_nx = SCORE;
            end
        end
    end

    always_comb begin
        phase_nx   = phase;
        blk_cnt_nx = blk_cnt;
        if (!blink_en) begin
            phase_nx   = 1'b1;
            blk_cnt_nx = BW'(BLINK_TICKS);
        end else if (tick) begin
            if (blk_cnt == BW'(1)) begin
                phase_nx   = !phase;
                blk_cnt_nx = BW'(BLINK_TICKS);
            end else begin
                blk_cnt_nx = blk_cnt - BW'(1);
            end
        end
    end

    // The output word is built from next-cycle values so it lines up with state.
    always_comb begin
        disp_nx = {score_a, score_b};
        src_nx  = SRC_SCORE;
        if (!phase_nx) begin
            disp_nx = 16'hFFFF;
            src_nx  = SRC_BLANK;
        end else if (state_nx == OVERLAY) begin
            disp_nx = ovl_reg_nx;
            src_nx  = SRC_OVERLAY;
        end
    end

    assign ovl_busy = (state == OVERLAY);

endmodule

// File: tb/tb_disp_scheduler.sv
// Self-checking bench for disp_scheduler: a tick-counting reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_disp_scheduler;

    localparam int HOLD  = 4;
    localparam int BLINK = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic [7:0]  score_a = 8'h07;
    logic [7:0]  score_b = 8'h11;
    logic        ovl_req = 1'b0;
    logic [15:0] ovl_data = 16'h0000;
    logic        ovl_clr = 1'b0;
    logic        blink_en = 1'b0;
    logic [15:0] disp_data;
    logic        ovl_ack;
    logic        ovl_busy;
    logic [1:0]  src;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit model_valid = 1'b0;

    disp_scheduler #(.HOLD_TICKS(HOLD), .BLINK_TICKS(BLINK)) dut (
        .clk(clk), .rst(rst), .tick(tick),
        .score_a(score_a), .score_b(score_b),
        .ovl_req(ovl_req), .ovl_data(ovl_data), .ovl_clr(ovl_clr),
        .blink_en(blink_en),
        .disp_data(disp_data), .ovl_ack(ovl_ack), .ovl_busy(ovl_busy), .src(src)
    );

    always #5 clk = ~clk;

    // Reference model: overlay tracked as "ticks left", blink as ticks since enable.
    bit          m_active;
    logic [15:0] m_msg;
    int          m_left;
    bit          m_ack;
    int          m_blink_ticks;
    logic [15:0] m_disp;
    logic [1:0]  m_src;

    always @(posedge clk or negedge rst) begin
        bit accept;
        bit blank;
        if (!rst) begin
            m_active = 0; m_msg = 16'h0000; m_left = 0; m_ack = 0;
            m_blink_ticks = 0; m_disp = 16'h0000; m_src = 2'd0;
        end else begin
            accept = ovl_req && !m_ack && !(m_active && ovl_clr);
            if (m_active && ovl_clr) begin
                m_active = 0;
                m_left = 0;
            end else if (accept) begin
                m_active = 1;
                m_msg = ovl_data;
                m_left = HOLD;
            end else if (m_active && tick) begin
                m_left = m_left - 1;
                if (m_left == 0) m_active = 0;
            end
            m_ack = accept;
            if (!blink_en) m_blink_ticks = 0;
            else if (tick) m_blink_ticks = m_blink_ticks + 1;
            blank = blink_en && (((m_blink_ticks / BLINK) % 2) == 1);
            m_disp = blank ? 16'hFFFF : (m_active ? m_msg : {score_a, score_b});
            m_src  = blank ? 2'd2 : (m_active ? 2'd1 : 2'd0);
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_valid) begin
            checkOutput("model_disp", disp_data, m_disp);
            checkOutput("model_src", {14'd0, src}, {14'd0, m_src});
            checkOutput("model_ack", {15'd0, ovl_ack}, {15'd0, m_ack});
            checkOutput("model_busy", {15'd0, ovl_busy}, {15'd0, m_active});
        end
    end

    task automatic applyStimulus(input int n);
        repeat (n) begin
            tick = (cyc % 3 == 0);
            cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic alignNoTick();
        while (cyc % 3 == 0) applyStimulus(1);
    endtask

    task automatic alignTick();
        while (cyc % 3 != 0) applyStimulus(1);
    endtask

    task automatic waitTicks(input int n);
        int seen = 0;
        int guard = 0;
        while (seen < n && guard < 100) begin
            applyStimulus(1);
            if (tick) seen++;
            guard++;
        end
        checkOutput("wait_ticks", 16'(seen), 16'(n));
    endtask

    task automatic runUntilIdle(output int ticks_seen);
        int guard = 0;
        bit was_busy;
        ticks_seen = 0;
        while (ovl_busy && guard < 60) begin
            was_busy = ovl_busy;
            applyStimulus(1);
            if (tick && was_busy) ticks_seen++;
            guard++;
        end
    endtask

    task automatic expectOut(input string name, input logic [15:0] d, input logic [1:0] s,
                             input logic busy, input logic ack);
        checkOutput({name, "_disp"}, disp_data, d);
        checkOutput({name, "_src"}, {14'd0, src}, {14'd0, s});
        checkOutput({name, "_busy"}, {15'd0, ovl_busy}, {15'd0, busy});
        checkOutput({name, "_ack"}, {15'd0, ovl_ack}, {15'd0, ack});
    endtask

    task automatic sendRequest(input logic [15:0] data, input logic [1:0] exp_src);
        ovl_data = data;
        ovl_req = 1'b1;
        applyStimulus(1);
        expectOut("accept", (exp_src == 2'd2) ? 16'hFFFF : data, exp_src, 1'b1, 1'b1);
        ovl_req = 1'b0;
    endtask

    initial begin
        int ticks;
        #2 rst = 1'b0;
        model_valid = 1'b1;
        applyStimulus(3);
        expectOut("in_reset", 16'h0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b1;
        applyStimulus(1);
        expectOut("after_reset", 16'h0711, 2'd0, 1'b0, 1'b0);

        $display("[TB] single overlay");
        alignNoTick();
        sendRequest(16'h1234, 2'd1);
        runUntilIdle(ticks);
        checkOutput("hold_ticks", 16'(ticks), 16'd4);
        expectOut("expired", 16'h0711, 2'd0, 1'b0, 1'b0);

        $display("[TB] replacement overlay");
        alignNoTick();
        sendRequest(16'h1234, 2'd1);
        waitTicks(2);
        expectOut("mid_first", 16'h1234, 2'd1, 1'b1, 1'b0);
        alignNoTick();
        sendRequest(16'h5678, 2'd1);
        runUntilIdle(ticks);
        checkOutput("restart_ticks", 16'(ticks), 16'd4);
        expectOut("expired2", 16'h0711, 2'd0, 1'b0, 1'b0);

        $display("[TB] abort with request and tick");
        alignNoTick();
        sendRequest(16'h1234, 2'd1);
        applyStimulus(1);
        alignTick();
        ovl_clr = 1'b1;
        ovl_req = 1'b1;
        ovl_data = 16'h9999;
        applyStimulus(1);
        expectOut("abort", 16'h0711, 2'd0, 1'b0, 1'b0);
        ovl_clr = 1'b0;
        ovl_req = 1'b0;
        applyStimulus(2);
        expectOut("abort_idle", 16'h0711, 2'd0, 1'b0, 1'b0);

        $display("[TB] blink over overlay");
        alignNoTick();
        blink_en = 1'b1;
        sendRequest(16'h1234, 2'd1);
        waitTicks(2);
        expectOut("blink_off1", 16'hFFFF, 2'd2, 1'b1, 1'b0);
        waitTicks(2);
        expectOut("blink_on_score", 16'h0711, 2'd0, 1'b0, 1'b0);
        waitTicks(2);
        expectOut("blink_off2", 16'hFFFF, 2'd2, 1'b0, 1'b0);
        waitTicks(2);
        expectOut("blink_on2", 16'h0711, 2'd0, 1'b0, 1'b0);
        waitTicks(2);
        expectOut("blink_off3", 16'hFFFF, 2'd2, 1'b0, 1'b0);
        blink_en = 1'b0;
        applyStimulus(1);
        expectOut("blink_stop", 16'h0711, 2'd0, 1'b0, 1'b0);

        $display("[TB] reset during blank overlay");
        alignNoTick();
        blink_en = 1'b1;
        sendRequest(16'h1234, 2'd1);
        waitTicks(2);
        expectOut("pre_reset", 16'hFFFF, 2'd2, 1'b1, 1'b0);
        #2 rst = 1'b0;
        #1;
        expectOut("async_reset", 16'h0000, 2'd0, 1'b0, 1'b0);
        applyStimulus(1);
        rst = 1'b1;
        applyStimulus(1);
        expectOut("post_reset", 16'h0711, 2'd0, 1'b0, 1'b0);
        blink_en = 1'b0;
        score_a = 8'h10;
        score_b = 8'h09;
        applyStimulus(1);
        expectOut("score_change", 16'h1009, 2'd0, 1'b0, 1'b0);
        applyStimulus(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
